gpio_port_ctrl: RTL and testbench
=================================

// Module: gpio_port_ctrl
// PURPOSE
//  Controller side of the GPIO pad interface. Drives sig_data_out/sig_data_oe and samples sig_data_in.
//  Registers are accessed via a simple req/ack register bus. Inputs are synchronised;
//  selected edges raise sticky interrupt status bits. Sits between the bus fabric and the pad ring.
// PARAMETERS
//  WIDTH            16  number of GPIO lines
//  DEBOUNCE_CYCLES  4   stable synchronised samples required before input accepted (GPIO_DEBOUNCE_EN only)
// PORTS
//  sig_clock     in   1      single clock, all logic rising-edge
//  sig_reset     in   1      synchronous, active-high reset
//  sig_data_in   in   WIDTH  pad input values (asynchronous)
//  sig_data_out  out  WIDTH  pad output values (= OUT register)
//  sig_data_oe   out  WIDTH  pad output enables, 1=drive (= OE register)
//  reg_req       in   1      register access request
//  reg_we        in   1      1=write, 0=read; qualified by reg_req
//  reg_addr      in   3      register index
//  reg_wdata     in   WIDTH  write data
//  reg_rdata     out  WIDTH  read data, valid while reg_ack=1
//  reg_ack       out  1      one-cycle access completion
//  irq           out  1      |(STATUS), registered
// BEHAVIOUR
//  Reset: sig_data_out=0, sig_data_oe=0, reg_rdata=0, reg_ack=0, irq=0; all regs, sync flops, debounce state =0.
//  Register map: 0 OUT(RW) 1 OE(RW) 2 IN(RO, synced/filtered value) 3 RISE_EN(RW) 4 FALL_EN(RW)
//   5 STATUS(RW1C); 6,7 read 0, writes ignored; writes to IN ignored.
//  Bus FSM: IDLE -> (reg_req) -> ACK -> IDLE. Request accepted only in IDLE; reg_req seen in ACK is ignored.
//   Write committed on accepting edge; reg_ack=1 for exactly the following cycle; reg_rdata captured
//   at accept, held valid with ack, then 0. Max throughput: one access per 2 cycles.
//  Input path: 2-flop synchroniser per bit; IN = stage2 (latency 2 edges pad->IN).
//  Edge detect: prev <= IN each cycle; rise = IN & ~prev & RISE_EN; fall = ~IN & prev & FALL_EN;
//   STATUS bit set on cycle after IN change (3 edges pad->STATUS); irq follows STATUS one cycle later.
//  STATUS W1C: bits written 1 clear; same-cycle new edge event on a bit wins (bit stays 1).
//  Enable changes do not retro-set STATUS; clearing an enable does not clear STATUS.
//  OUT/OE change visible on pads the cycle after write accept (registered outputs, no OE gating of OUT).
//  Reset mid-access: FSM returns to IDLE, ack suppressed, write in flight discarded.
// CONFIGURATION
//  GPIO_DEBOUNCE_EN defined: per-bit counter between stage2 and IN; IN bit updates only after stage2 differs
//   from IN for DEBOUNCE_CYCLES consecutive cycles; counter resets on any bounce back. Latency pad->IN = 2+DEBOUNCE_CYCLES.
//  Undefined: no filter, IN = stage2 directly; no counters instantiated.
// TESTING
//  Reset then read all 8 addrs -> every reg_rdata = 0x0000, sig_data_oe=0, irq=0.
//  Write OUT=0x00AA, OE=0x00FF -> pads show 0x00AA/0x00FF cycle after accept; readback matches.
//  sig_data_in=0x0064, RISE_EN=0xFFFF -> IN reads 0x0064; STATUS=0x0064; irq=1; write STATUS=0x0004 -> 0x0060.
//  FALL_EN=0x0001, drop bit0 in the same cycle STATUS bit0 is W1C-written -> STATUS bit0 remains 1.
//  reg_req held high 4 cycles -> exactly 2 acks, on cycles 2 and 4; access to addr 7 reads 0.
//  GPIO_DEBOUNCE_EN: 3-cycle pulse on bit3 -> IN, STATUS unchanged; 6-cycle level -> IN bit3=1 after 2+4 cycles.

Source files
------------

// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl: controller side of a GPIO pad interface.
//
// Drives the pad output value and output enable. Samples the pad inputs through a
// two-flop synchroniser. Rising and falling edges on the sampled inputs set sticky,
// write-1-to-clear status bits. A simple req/ack register bus gives access to the
// registers. The bus accepts one access per two cycles.
//
// Configuration macro: GPIO_DEBOUNCE_EN
//   defined   - a per-bit debounce counter sits between the synchroniser and IN.
//               IN takes the new value only after the synchroniser output has
//               differed from IN for DEBOUNCE_CYCLES consecutive cycles.
//   undefined - IN is the synchroniser output. No counters are built.
//
// Ports:
//   sig_clock     in   1      clock, rising edge
//   sig_reset     in   1      synchronous, active-high reset
//   sig_data_in   in   WIDTH  pad input values (asynchronous)
//   sig_data_out  out  WIDTH  pad output values (OUT register)
//   sig_data_oe   out  WIDTH  pad output enables, 1 = drive (OE register)
//   reg_req       in   1      register access request
//   reg_we        in   1      1 = write, 0 = read
//   reg_addr      in   3      register index
//   reg_wdata     in   WIDTH  write data
//   reg_rdata     out  WIDTH  read data, valid while reg_ack = 1, otherwise 0
//   reg_ack       out  1      one-cycle access completion
//   irq           out  1      OR of STATUS, registered
//
// Register map:
//   0 OUT, 1 OE, 2 IN (read-only), 3 RISE_EN, 4 FALL_EN, 5 STATUS (W1C), 6/7 read 0.

module gpio_port_ctrl #(
    parameter int unsigned WIDTH = 16
`ifdef GPIO_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CYCLES = 4
`endif
) (
    input  logic             sig_clock,
    input  logic             sig_reset,
    input  logic [WIDTH-1:0] sig_data_in,
    output logic [WIDTH-1:0] sig_data_out,
    output logic [WIDTH-1:0] sig_data_oe,
    input  logic             reg_req,
    input  logic             reg_we,
    input  logic [2:0]       reg_addr,
    input  logic [WIDTH-1:0] reg_wdata,
    output logic [WIDTH-1:0] reg_rdata,
    output logic             reg_ack,
    output logic             irq
);

    typedef enum logic [0:0] {StIdle, StAck} bus_state_e;

    bus_state_e       state_q, state_d;
    logic             accept;
    logic             wr_en;

    logic [WIDTH-1:0] out_q, oe_q, rise_en_q, fall_en_q;
    logic [WIDTH-1:0] status_q, status_d, status_clr;
    logic [WIDTH-1:0] sync1_q, sync2_q, in_val, prev_q, events;
    logic [WIDTH-1:0] rd_mux, rdata_q;
    logic             irq_q;

    // A request counts only in IDLE. Requests seen during the ack cycle are dropped.
    assign accept = (state_q == StIdle) && reg_req;
    assign wr_en  = accept && reg_we;

    // Bus FSM: state register
    always_ff @(posedge sig_clock) begin
        if (sig_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (reg_req) state_d = StAck;
            StAck:  state_d = StIdle;
        endcase
    end

    // Bus FSM: outputs
    always_comb begin
        reg_ack = (state_q == StAck);
    end

    // Input synchroniser and edge history
    always_ff @(posedge sig_clock) begin
        if (sig_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sig_data_in;
            sync2_q <= sync1_q;
            prev_q  <= in_val;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0][CntW-1:0] db_cnt_q;
    logic [WIDTH-1:0]           in_q;

    // The counter tracks how long stage 2 has disagreed with IN. Any agreement
    // (a bounce back) restarts the count.
    always_ff @(posedge sig_clock) begin
        if (sig_reset) begin
            db_cnt_q <= '0;
            in_q     <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (sync2_q[i] != in_q[i]) begin
                    if (db_cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
                        in_q[i]     <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign in_val = in_q;
`else
    assign in_val = sync2_q;
`endif

    assign events = (in_val & ~prev_q & rise_en_q) | (~in_val & prev_q & fall_en_q);

    // A new edge event on the same cycle as a W1C keeps the bit set.
    always_comb begin
        status_clr = '0;
        if (wr_en && (reg_addr == 3'd5)) begin
            status_clr = reg_wdata;
        end
        status_d = (status_q & ~status_clr) | events;
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            3'd0:    rd_mux = out_q;
            3'd1:    rd_mux = oe_q;
            3'd2:    rd_mux = in_val;
            3'd3:    rd_mux = rise_en_q;
            3'd4:    rd_mux = fall_en_q;
            3'd5:    rd_mux = status_q;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge sig_clock) begin
        if (sig_reset) begin
            out_q     <= '0;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_en) begin
                case (reg_addr)
                    3'd0:    out_q     <= reg_wdata;
                    3'd1:    oe_q      <= reg_wdata;
                    3'd3:    rise_en_q <= reg_wdata;
                    3'd4:    fall_en_q <= reg_wdata;
                    default: ;
                endcase
            end
            status_q <= status_d;
            // Read data lives only for the ack cycle. It is zero at all other times.
            rdata_q  <= (accept && !reg_we) ? rd_mux : '0;
            irq_q    <= |status_q;
        end
    end

    assign sig_data_out = out_q;
    assign sig_data_oe  = oe_q;
    assign reg_rdata    = rdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Self-checking bench for gpio_port_ctrl. For every bus access, the expected read
// data is pushed to a scoreboard queue. A monitor pops an entry on each reg_ack and
// compares the read data with it.

module tb_gpio_port_ctrl;

`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        sig_reset;
    logic [15:0] sig_data_in;
    logic [15:0] sig_data_out;
    logic [15:0] sig_data_oe;
    logic        reg_req;
    logic        reg_we;
    logic [2:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;
    logic        reg_ack;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] exp;
        logic        is_rd;
    } sb_t;

    sb_t sb_q[$];

    gpio_port_ctrl dut (
        .sig_clock    (clk),
        .sig_reset    (sig_reset),
        .sig_data_in  (sig_data_in),
        .sig_data_out (sig_data_out),
        .sig_data_oe  (sig_data_oe),
        .reg_req      (reg_req),
        .reg_we       (reg_we),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .reg_ack      (reg_ack),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one access at a negedge and releases it at the next negedge.
    task automatic bus(input logic we, input logic [2:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp, input string tag);
        sb_t e;
        @(negedge clk);
        reg_req   = 1'b1;
        reg_we    = we;
        reg_addr  = addr;
        reg_wdata = wdata;
        e.tag   = tag;
        e.exp   = exp;
        e.is_rd = !we;
        sb_q.push_back(e);
        @(negedge clk);
        reg_req = 1'b0;
        reg_we  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        bus(1'b1, addr, data, 16'h0, "wr");
    endtask

    task automatic rd(input logic [2:0] addr, input logic [15:0] exp, input string tag);
        bus(1'b0, addr, 16'h0, exp, tag);
    endtask

    // Scoreboard monitor
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (reg_ack) begin
                if (sb_q.size() == 0) begin
                    check("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    if (e.is_rd) check(e.tag, {16'h0, reg_rdata}, {16'h0, e.exp});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sig_reset   = 1'b1;
        sig_data_in = 16'h0;
        reg_req     = 1'b0;
        reg_we      = 1'b0;
        reg_addr    = 3'd0;
        reg_wdata   = 16'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out", {16'h0, sig_data_out}, 32'h0);
        check("rst_oe", {16'h0, sig_data_oe}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_ack", {31'h0, reg_ack}, 32'h0);
        check("rst_rdata", {16'h0, reg_rdata}, 32'h0);
        sig_reset = 1'b0;

        for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, "rst_read");

        // OUT / OE reach the pads the cycle after accept
        wr(3'd0, 16'h00AA);
        check("pad_out", {16'h0, sig_data_out}, 32'h00AA);
        wr(3'd1, 16'h00FF);
        check("pad_oe", {16'h0, sig_data_oe}, 32'h00FF);
        rd(3'd0, 16'h00AA, "rb_out");
        rd(3'd1, 16'h00FF, "rb_oe");

        // Rising edges set STATUS; W1C
        wr(3'd3, 16'hFFFF);
        @(negedge clk);
        sig_data_in = 16'h0064;
        repeat (LAT + 3) @(negedge clk);
        rd(3'd2, 16'h0064, "in_val");
        rd(3'd5, 16'h0064, "status_rise");
        check("irq_set", {31'h0, irq}, 32'h1);
        wr(3'd5, 16'h0004);
        rd(3'd5, 16'h0060, "status_w1c");

        // A fall event on the same edge as a W1C of that bit keeps the bit set
        @(negedge clk);
        sig_data_in = 16'h0065;
        repeat (LAT + 3) @(negedge clk);
        rd(3'd5, 16'h0061, "status_bit0");
        wr(3'd4, 16'h0001);
        @(negedge clk);
        sig_data_in = 16'h0064;
        repeat (LAT - 1) @(negedge clk);
        wr(3'd5, 16'h0001);
        rd(3'd5, 16'h0061, "event_wins");
        wr(3'd5, 16'h0001);
        rd(3'd5, 16'h0060, "w1c_bit0");

        wr(3'd5, 16'hFFFF);
        repeat (2) @(negedge clk);
        check("irq_clr", {31'h0, irq}, 32'h0);
        rd(3'd5, 16'h0000, "status_clr_all");

        // Enable changes do not set STATUS retroactively
        wr(3'd3, 16'h0000);
        wr(3'd3, 16'hFFFF);
        rd(3'd5, 16'h0000, "no_retro");

        // Clearing an enable leaves STATUS alone
        @(negedge clk);
        sig_data_in = 16'h0164;
        repeat (LAT + 3) @(negedge clk);
        wr(3'd3, 16'h0000);
        rd(3'd5, 16'h0100, "en_clr_keeps");
        check("irq_bit8", {31'h0, irq}, 32'h1);

`ifdef GPIO_DEBOUNCE_EN
        // A 3-cycle pulse is filtered out
        wr(3'd3, 16'hFFFF);
        wr(3'd5, 16'hFFFF);
        @(negedge clk);
        sig_data_in = 16'h016C;
        repeat (3) @(negedge clk);
        sig_data_in = 16'h0164;
        repeat (10) @(negedge clk);
        rd(3'd2, 16'h0164, "db_pulse_in");
        rd(3'd5, 16'h0000, "db_pulse_status");
`endif

        // Latency pad -> IN: still old at edge LAT, new afterwards
        @(negedge clk);
        sig_data_in = 16'h016C;
        repeat (LAT - 2) @(negedge clk);
        rd(3'd2, 16'h0164, "in_lat_pre");
        rd(3'd2, 16'h016C, "in_lat_post");

        // reg_req held for 4 cycles gives acks in cycles 2 and 4
        begin
            sb_t e;
            e.tag = "held_rd7"; e.exp = 16'h0; e.is_rd = 1'b1;
            sb_q.push_back(e);
            sb_q.push_back(e);
        end
        @(negedge clk);
        reg_req  = 1'b1;
        reg_we   = 1'b0;
        reg_addr = 3'd7;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("held_ack", {31'h0, reg_ack}, (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        reg_req = 1'b0;
        @(negedge clk);
        check("rdata_idle", {16'h0, reg_rdata}, 32'h0);

        // Reset during an access: no ack, and the write is lost
        @(negedge clk);
        reg_req   = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = 3'd0;
        reg_wdata = 16'h1234;
        sig_reset = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", {31'h0, reg_ack}, 32'h0);
        check("rst_mid_out", {16'h0, sig_data_out}, 32'h0);
        reg_req   = 1'b0;
        reg_we    = 1'b0;
        sig_reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ack2", {31'h0, reg_ack}, 32'h0);
        rd(3'd0, 16'h0000, "rst_mid_rb");

        repeat (3) @(negedge clk);
        check("sb_drain", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
